// File: rtl/ex_muldiv_unit_pkg.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit_pkg
//   Shared decode constants for the multiply/divide unit. The hazard unit and
//   the main decoder import the same constants so all three agree on which
//   instructions belong to the MD class.
//
//   Contents:
//     OP_RTYPE          R-type opcode; MD instructions are only decoded under it
//     FUNC_*            function codes for mult/multu/div/divu/mfhi/mthi/mflo/mtlo
//     CNT_W             width of the latency counter
//     mdu_state_t       two-state FSM encoding (IDLE / RUN)
//     is_md_start()     op/func decode of mult/multu/div/divu
//     is_div_func()     func decode of div/divu
// ----------------------------------------------------------------------------
package ex_muldiv_unit_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;

    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    // Wide enough for any realistic MULT_CYCLES / DIV_CYCLES setting.
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_md_start(input logic [5:0] op, input logic [5:0] func);
        return (op == OP_RTYPE) &&
               ((func == FUNC_MULT) || (func == FUNC_MULTU) ||
                (func == FUNC_DIV)  || (func == FUNC_DIVU));
    endfunction

    function automatic logic is_div_func(input logic [5:0] func);
        return (func == FUNC_DIV) || (func == FUNC_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_muldiv_core.sv
// ----------------------------------------------------------------------------
// muldiv_core
//   Purely combinational arithmetic for the MD unit. Produces the HI/LO pair
//   that a mult/multu/div/divu with the given operands would write.
//
//   Ports:
//     func    in  6   function field selecting the operation
//     rs_val  in  32  first operand (multiplicand / dividend)
//     rt_val  in  32  second operand (multiplier / divisor)
//     res_hi  out 32  product[63:32] or remainder
//     res_lo  out 32  product[31:0]  or quotient
//
//   For a zero divisor the outputs are meaningless; the caller suppresses the
//   HI/LO write in that case.
// ----------------------------------------------------------------------------
module muldiv_core
    import ex_muldiv_unit_pkg::*;
(
    input  logic [5:0]  func,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_b_s;
    logic [31:0] div_b_u;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    // Sign-extending both operands to 64 bits makes the low 64 bits of the
    // product equal to the exact signed product.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed division is done on magnitudes with the signs reapplied, which
    // gives truncation toward zero and a remainder carrying the dividend's
    // sign. 0x80000000 / -1 falls out as 0x80000000 with remainder 0, since
    // its magnitude is representable as an unsigned 32-bit value.
    assign abs_a   = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign abs_b   = rt_val[31] ? (~rt_val + 32'd1) : rt_val;

    // Divisors forced non-zero so the dividers never see 0.
    assign div_b_s = (abs_b  == 32'd0) ? 32'd1 : abs_b;
    assign div_b_u = (rt_val == 32'd0) ? 32'd1 : rt_val;

    assign q_mag   = abs_a / div_b_s;
    assign r_mag   = abs_a % div_b_s;
    assign q_s     = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s     = rs_val[31] ? (~r_mag + 32'd1) : r_mag;

    assign q_u     = rs_val / div_b_u;
    assign r_u     = rs_val % div_b_u;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (func)
            FUNC_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            FUNC_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            FUNC_DIV: begin
                res_hi = r_s;
                res_lo = q_s;
            end
            FUNC_DIVU: begin
                res_hi = r_u;
                res_lo = q_u;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
//   EX-stage multiply/divide unit. Owns the architectural HI/LO registers,
//   runs mult/multu/div/divu as fixed-latency multi-cycle operations and
//   serves mfhi/mflo/mthi/mtlo.
//
//   Parameters:
//     MULT_CYCLES  cycles from start edge until a mult result is in HI/LO
//     DIV_CYCLES   cycles from start edge until a div result is in HI/LO
//
//   Ports:
//     clk      in  1   clock
//     reset    in  1   synchronous, active-high
//     op       in  6   opcode from ID/EX
//     func     in  6   function field from ID/EX
//     rs_val   in  32  forwarded rs operand
//     rt_val   in  32  forwarded rt operand
//     start    out 1   EX holds mult/multu/div/divu (combinational decode)
//     busy     out 1   an operation is in flight
//     hi       out 32  HI register
//     lo       out 32  LO register
//     mdu_out  out 32  hi when func is mfhi, otherwise lo
// ----------------------------------------------------------------------------
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    mdu_state_t       state;
    logic [CNT_W-1:0] counter;
    logic [31:0]      pending_hi;
    logic [31:0]      pending_lo;
    logic             pending_we;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             is_div_op;
    logic             is_mthi;
    logic             is_mtlo;

    assign start     = is_md_start(op, func);
    assign is_div_op = is_div_func(func);
    assign is_mthi   = (op == OP_RTYPE) && (func == FUNC_MTHI);
    assign is_mtlo   = (op == OP_RTYPE) && (func == FUNC_MTLO);

    // Combinational so an mfhi/mflo right after busy falls sees the new value.
    assign mdu_out   = (func == FUNC_MFHI) ? hi : lo;

    muldiv_core u_core (
        .func   (func),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // The result is captured on the start edge (operands are only valid
    // then) and held until the counter expires. A divide by zero still
    // occupies the unit for the full latency but leaves HI/LO untouched.
    // start/mthi/mtlo are only honoured in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            counter    <= '0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            pending_we <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pending_hi <= res_hi;
                        pending_lo <= res_lo;
                        pending_we <= !(is_div_op && (rt_val == 32'd0));
                        counter    <= is_div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy       <= 1'b1;
                        state      <= ST_RUN;
                    end else if (is_mthi) begin
                        hi <= rs_val;
                    end else if (is_mtlo) begin
                        lo <= rs_val;
                    end
                end
                ST_RUN: begin
                    counter <= counter - 1'b1;
                    if (counter == CNT_W'(1)) begin
                        if (pending_we) begin
                            hi <= pending_hi;
                            lo <= pending_lo;
                        end
                        pending_we <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
